// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - binary32 field widths, constants, FSM states and pack/unpack helpers
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic signed [9:0] BIAS  = 10'sd127;
  localparam logic signed [9:0] EMIN  = -10'sd126;
  localparam logic signed [9:0] EMAX  = 10'sd127;
  localparam logic [31:0]       QNAN  = 32'h7FC00000;

  typedef enum logic [3:0] {
    GET, UNPACK, SPECIAL, ALIGN, ADD0, ADD1, NORM1, NORM2, ROUND, PACK, PUT
  } state_t;

  // Mantissa carries hidden bit at [26] and guard/round/sticky room at [2:0].
  typedef struct packed {
    logic              s;
    logic signed [9:0] e;
    logic [26:0]       m;
  } unpacked_t;

  function automatic unpacked_t unpack(input logic [31:0] w);
    unpacked_t u;
    u.s = w[31];
    u.e = $signed({2'b00, w[30:30-EXP_W+1]}) - BIAS;
    u.m = {1'b0, w[MAN_W-1:0], 3'b000};
    return u;
  endfunction

  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic [23:0] m);
    logic signed [9:0] eb;
    eb = e + BIAS;
    if (m == 24'd0)
      pack = 32'd0;
    else if (e > EMAX)
      pack = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e == EMIN && !m[23])
      pack = {s, {EXP_W{1'b0}}, m[MAN_W-1:0]};
    else
      pack = {s, eb[EXP_W-1:0], m[MAN_W-1:0]};
  endfunction

endpackage

// File: rtl/fp32_round.sv
// rtl/fp32_round.sv - round-to-nearest-even on guard/round/sticky, plus final packing
module fp32_round
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [23:0]       man_in,
  input  logic              guard,
  input  logic              round_bit,
  input  logic              sticky,
  output logic signed [9:0] exp_rnd,
  output logic [23:0]       man_rnd,
  output logic [31:0]       packed_z
);

  logic round_up;

  always_comb begin
    round_up = guard && (round_bit || sticky || man_in[0]);
    exp_rnd  = exp_in;
    man_rnd  = man_in;
    if (round_up) begin
      // All-ones mantissa wraps to 1.0 at the next binade.
      if (man_in == 24'hFFFFFF) begin
        man_rnd = 24'h800000;
        exp_rnd = exp_in + 10'sd1;
      end else begin
        man_rnd = man_in + 24'd1;
      end
    end
  end

  assign packed_z = pack(sign, exp_in, man_in);

endmodule

// File: rtl/fp32_adder.sv
// rtl/fp32_adder.sv - free-running multi-cycle binary32 adder/subtractor
module fp32_adder
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic [31:0] output_z,
  output logic        output_z_stb
);

  state_t state_q, state_d;

  logic [31:0]       a_w, b_w, z;
  logic              a_s, b_s, z_s;
  logic signed [9:0] a_e, b_e, z_e;
  logic [26:0]       a_m, b_m;
  logic [27:0]       sum;
  logic [23:0]       z_m;
  logic              guard, round_bit, sticky;

  unpacked_t         ua, ub;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [31:0]       special_z;
  logic signed [9:0] a_e_adj, b_e_adj, e_diff;
  logic [26:0]       a_m_adj, b_m_adj;
  logic signed [9:0] exp_rnd;
  logic [23:0]       man_rnd;
  logic [31:0]       packed_z;

  assign ua = unpack(a_w);
  assign ub = unpack(b_w);

  always_comb begin
    a_nan  = (a_e == 10'sd128) && (a_m[25:3] != 23'd0);
    b_nan  = (b_e == 10'sd128) && (b_m[25:3] != 23'd0);
    a_inf  = (a_e == 10'sd128) && (a_m[25:3] == 23'd0);
    b_inf  = (b_e == 10'sd128) && (b_m[25:3] == 23'd0);
    a_zero = (a_e == -10'sd127) && (a_m[25:3] == 23'd0);
    b_zero = (b_e == -10'sd127) && (b_m[25:3] == 23'd0);
    special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;

    special_z = 32'd0;
    if (a_nan || b_nan)
      special_z = QNAN;
    else if (a_inf)
      special_z = (b_inf && (a_s != b_s)) ? QNAN : {a_s, 8'hFF, 23'd0};
    else if (b_inf)
      special_z = {b_s, 8'hFF, 23'd0};
    else if (a_zero && b_zero)
      special_z = {a_s & b_s, 31'd0};
    else if (a_zero)
      special_z = b_w;
    else if (b_zero)
      special_z = a_w;

    // Denormals sit at EMIN without the hidden bit.
    a_e_adj = (a_e == -10'sd127) ? EMIN : a_e;
    b_e_adj = (b_e == -10'sd127) ? EMIN : b_e;
    a_m_adj = (a_e == -10'sd127) ? a_m : (a_m | 27'h4000000);
    b_m_adj = (b_e == -10'sd127) ? b_m : (b_m | 27'h4000000);
    e_diff  = a_e - b_e;
  end

  fp32_round u_round (
    .sign      (z_s),
    .exp_in    (z_e),
    .man_in    (z_m),
    .guard     (guard),
    .round_bit (round_bit),
    .sticky    (sticky),
    .exp_rnd   (exp_rnd),
    .man_rnd   (man_rnd),
    .packed_z  (packed_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= GET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET:     state_d = UNPACK;
      UNPACK:  state_d = SPECIAL;
      SPECIAL: begin
        if (special)                 state_d = PUT;
        else if (a_e_adj != b_e_adj) state_d = ALIGN;
        else                         state_d = ADD0;
      end
      ALIGN:   if (e_diff == 10'sd1 || e_diff == -10'sd1) state_d = ADD0;
      ADD0:    state_d = ADD1;
      ADD1:    state_d = NORM1;
      NORM1: begin
        if (!z_m[23] && z_e > EMIN) state_d = NORM1;
        else if (z_e < EMIN)        state_d = NORM2;
        else                        state_d = ROUND;
      end
      NORM2:   if (z_e >= EMIN - 10'sd1) state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = PUT;
      PUT:     state_d = GET;
      default: state_d = GET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_w <= '0; b_w <= '0; z <= '0;
      a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      a_m <= '0; b_m <= '0; sum <= '0; z_m <= '0;
      guard <= 1'b0; round_bit <= 1'b0; sticky <= 1'b0;
      output_z <= '0;
      output_z_stb <= 1'b0;
    end else begin
      output_z_stb <= (state_q == PUT);
      case (state_q)
        GET: begin
          a_w <= input_a;
          b_w <= {input_b[31] ^ sel, input_b[30:0]};
        end
        UNPACK: begin
          a_s <= ua.s; a_e <= ua.e; a_m <= ua.m;
          b_s <= ub.s; b_e <= ub.e; b_m <= ub.m;
        end
        SPECIAL: begin
          z   <= special_z;
          a_e <= a_e_adj; a_m <= a_m_adj;
          b_e <= b_e_adj; b_m <= b_m_adj;
        end
        ALIGN: begin
          // Shifted-out bits collapse into bit 0 as sticky.
          if (a_e > b_e) begin
            b_e <= b_e + 10'sd1;
            b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
          end else begin
            a_e <= a_e + 10'sd1;
            a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
          end
        end
        ADD0: begin
          z_e <= a_e;
          if (a_s == b_s) begin
            sum <= {1'b0, a_m} + {1'b0, b_m};
            z_s <= a_s;
          end else if (a_m >= b_m) begin
            sum <= {1'b0, a_m} - {1'b0, b_m};
            z_s <= a_s;
          end else begin
            sum <= {1'b0, b_m} - {1'b0, a_m};
            z_s <= b_s;
          end
        end
        ADD1: begin
          if (sum[27]) begin
            z_m <= sum[27:4]; guard <= sum[3]; round_bit <= sum[2];
            sticky <= sum[1] | sum[0];
            z_e <= z_e + 10'sd1;
          end else begin
            z_m <= sum[26:3]; guard <= sum[2]; round_bit <= sum[1];
            sticky <= sum[0];
          end
        end
        NORM1: begin
          if (!z_m[23] && z_e > EMIN) begin
            z_e <= z_e - 10'sd1;
            z_m <= {z_m[22:0], guard};
            guard <= round_bit;
            round_bit <= 1'b0;
          end
        end
        NORM2: begin
          if (z_e < EMIN) begin
            z_e <= z_e + 10'sd1;
            z_m <= {1'b0, z_m[23:1]};
            guard <= z_m[0];
            round_bit <= guard;
            sticky <= sticky | round_bit;
          end
        end
        ROUND: begin
          z_e <= exp_rnd;
          z_m <= man_rnd;
        end
        PACK: z <= packed_z;
        PUT:  output_z <= z;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_adder.sv
// tb/tb_fp32_adder.sv - directed vector bench for fp32_adder
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] input_a, input_b, output_z;
  logic        output_z_stb;

  int n_checks = 0;
  int n_fail   = 0;

  fp32_adder dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .input_a      (input_a),
    .input_b      (input_b),
    .output_z     (output_z),
    .output_z_stb (output_z_stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] z);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.z = z;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_stb(input string name);
    logic [31:0] held;
    bit got, moved;
    held = output_z; got = 0; moved = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (output_z_stb) begin
        got = 1;
        break;
      end
      if (output_z !== held) moved = 1;
    end
    check($sformatf("%s strobe", name), {31'd0, got}, 32'd1);
    check($sformatf("%s stable", name), {31'd0, moved}, 32'd0);
  endtask

  task automatic pulse_width(input string name);
    @(negedge clk);
    check($sformatf("%s stb_one_cycle", name), {31'd0, output_z_stb}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add_vec(32'h41A00000, 32'hC1200000, 1'b0, 32'h41200000);
    add_vec(32'h42200000, 32'h41F00000, 1'b0, 32'h428C0000);
    add_vec(32'h42200000, 32'h41F00000, 1'b1, 32'h41200000);
    add_vec(32'hC2200000, 32'hC1F00000, 1'b0, 32'hC28C0000);
    add_vec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000);
    add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    add_vec(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000);
    add_vec(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000);
    add_vec(32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
    add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000);
    add_vec(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
    add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    add_vec(32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002);
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    add_vec(32'h00000001, 32'h00000001, 1'b0, 32'h00000002);
    add_vec(32'h00400000, 32'h00400000, 1'b0, 32'h00800000);

    rst = 1'b1; sel = 1'b0; input_a = 32'd0; input_b = 32'd0;
    #1;
    check("reset output_z", output_z, 32'd0);
    check("reset stb", {31'd0, output_z_stb}, 32'd0);

    // Each vector starts from reset; operands are scrambled after GET to prove they were latched.
    foreach (vecs[i]) begin
      rst = 1'b1;
      input_a = vecs[i].a; input_b = vecs[i].b; sel = vecs[i].s;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      input_a = 32'h12345678; input_b = 32'h9ABCDEF0; sel = ~vecs[i].s;
      wait_stb($sformatf("vec%0d", i));
      check($sformatf("vec%0d result", i), output_z, vecs[i].z);
      pulse_width($sformatf("vec%0d", i));
    end

    // Free-running with an exponent gap of 20, then reset during the next alignment.
    rst = 1'b1;
    input_a = 32'h49800000; input_b = 32'h3F800000; sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_stb("gap20 first");
    check("gap20 first result", output_z, 32'h49800008);
    wait_stb("gap20 second");
    check("gap20 second result", output_z, 32'h49800008);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midalign reset output_z", output_z, 32'd0);
    check("midalign reset stb", {31'd0, output_z_stb}, 32'd0);
    repeat (3) @(negedge clk);
    check("midalign held stb", {31'd0, output_z_stb}, 32'd0);
    rst = 1'b0;
    wait_stb("after reset");
    check("after reset result", output_z, 32'h49800008);
    pulse_width("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
